// File: rtl/note_sched_pkg.sv
// Shared types and constants for the note scheduler: FSM state encoding,
// note index names and the note-select width helper.
package note_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StPlay,
        StDrain,
        StSustain
    } state_e;

    localparam int unsigned NOTE_C4 = 0;
    localparam int unsigned NOTE_D4 = 1;
    localparam int unsigned NOTE_E4 = 2;
    localparam int unsigned NOTE_F4 = 3;
    localparam int unsigned NOTE_G4 = 4;
    localparam int unsigned NOTE_A4 = 5;
    localparam int unsigned NOTE_B4 = 6;
    localparam int unsigned NOTE_C5 = 7;

    function automatic int unsigned note_w(input int unsigned num_notes);
        return (num_notes > 1) ? $clog2(num_notes) : 1;
    endfunction

endpackage

// File: rtl/note_priority_enc.sv
// Combinational lowest-index priority encoder for synchronised key levels;
// index 0 (C4) has the highest priority.
module note_priority_enc #(
    parameter int unsigned NUM_NOTES = 8,
    parameter int unsigned NOTE_W    = 3
) (
    input  logic [NUM_NOTES-1:0] keys_i,
    output logic [NOTE_W-1:0]    winner_o,
    output logic                 any_key_o
);

    // Scanning downwards lets the lowest set index overwrite any higher one.
    always_comb begin
        winner_o = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (keys_i[i]) begin
                winner_o = NOTE_W'(i);
            end
        end
    end

    assign any_key_o = |keys_i;

endmodule

// File: rtl/note_scheduler.sv
// Arbitrates key requests onto one speaker, switching notes only in the low phase.
// Define NOTE_SCHED_SUSTAIN_EN to keep a released note sounding for SUSTAIN_CYCLES.
module note_scheduler
    import note_sched_pkg::*;
#(
    parameter int unsigned NUM_NOTES      = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SUSTAIN_CYCLES = 1000,
    localparam int unsigned NOTE_W        = note_w(NUM_NOTES)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NUM_NOTES-1:0] KEYS,
    input  logic [NUM_NOTES-1:0] NOTE_CLKS,
    output logic                 SPEAKER,
    output logic [NOTE_W-1:0]    NOTE_SEL,
    output logic                 NOTE_VALID
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (SUSTAIN_CYCLES < 1) begin : g_bad_sustain
        $error("SUSTAIN_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0][NUM_NOTES-1:0] sync_q, sync_d;
    logic [NUM_NOTES-1:0] keys_s;
    logic [NOTE_W-1:0]    winner;
    logic                 any_key;

    state_e            state_q, state_d;
    logic [NOTE_W-1:0] sel_q, sel_d;
    logic              speaker_q, speaker_d;
    logic              note_clk;
    logic              key_sel;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], KEYS};
    assign keys_s = sync_q[SYNC_STAGES-1];

    note_priority_enc #(
        .NUM_NOTES (NUM_NOTES),
        .NOTE_W    (NOTE_W)
    ) u_prio (
        .keys_i    (keys_s),
        .winner_o  (winner),
        .any_key_o (any_key)
    );

    assign note_clk = NOTE_CLKS[sel_q];
    assign key_sel  = keys_s[sel_q];

`ifdef NOTE_SCHED_SUSTAIN_EN
    localparam int unsigned CNT_W = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        speaker_d = 1'b0;
`ifdef NOTE_SCHED_SUSTAIN_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_key) begin
                    sel_d   = winner;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (!key_sel) begin
                    state_d = StIdle;
                end else if (!note_clk) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                speaker_d = note_clk;
                if (!key_sel || (winner < sel_q)) begin
`ifdef NOTE_SCHED_SUSTAIN_EN
                    if (!any_key) begin
                        state_d = StSustain;
                        cnt_d   = CNT_W'(SUSTAIN_CYCLES - 1);
                    end else begin
                        state_d = StDrain;
                    end
`else
                    state_d = StDrain;
`endif
                end
            end
`ifdef NOTE_SCHED_SUSTAIN_EN
            StSustain: begin
                speaker_d = note_clk;
                if (any_key || (cnt_q == '0)) begin
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            // Keep following until the low phase so the last pulse is never cut short.
            StDrain: begin
                speaker_d = note_clk;
                if (!note_clk) begin
                    if (any_key) begin
                        sel_d   = winner;
                        state_d = StArm;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q    <= '0;
            state_q   <= StIdle;
            sel_q     <= NOTE_W'(NOTE_C4);
            speaker_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            speaker_q <= speaker_d;
        end
    end

    assign SPEAKER    = speaker_q;
    assign NOTE_SEL   = sel_q;
    assign NOTE_VALID = (state_q == StPlay) || (state_q == StSustain);

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler: steady-state vector table, hand-written
// corner sequences and randomized key traffic against a behavioural reference model.
module tb_note_scheduler;

    localparam int NN = 8;
    localparam int SS = 2;
    localparam int SC = 10;

    logic          CLK;
    logic          RESET;
    logic [NN-1:0] KEYS;
    logic [NN-1:0] note_clks;
    logic          SPEAKER;
    logic [2:0]    NOTE_SEL;
    logic          NOTE_VALID;

    note_scheduler #(
        .NUM_NOTES      (NN),
        .SYNC_STAGES    (SS),
        .SUSTAIN_CYCLES (SC)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .KEYS       (KEYS),
        .NOTE_CLKS  (note_clks),
        .SPEAKER    (SPEAKER),
        .NOTE_SEL   (NOTE_SEL),
        .NOTE_VALID (NOTE_VALID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Note clock generator: note i has a half-period of 3+i cycles.
    int nc_cnt[NN];
    bit stuck[NN];

    function automatic int half_period(input int idx);
        return 3 + idx;
    endfunction

    task automatic advance_nc();
        for (int i = 0; i < NN; i++) begin
            if (!stuck[i]) begin
                nc_cnt[i]++;
                if (nc_cnt[i] >= half_period(i)) begin
                    nc_cnt[i] = 0;
                    note_clks[i] = ~note_clks[i];
                end
            end
        end
    endtask

    // Reference model: which note is sounding, described by the arbitration rules.
    localparam int M_IDLE = 0, M_ARM = 1, M_PLAY = 2, M_DRAIN = 3, M_SUS = 4;
    int m_mode, m_sel, m_cnt;
    bit m_spk;
    bit [NN-1:0] hist[$];

    function automatic int lowest(input bit [NN-1:0] k);
        for (int i = 0; i < NN; i++) if (k[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_sel  = 0;
        m_cnt  = 0;
        m_spk  = 0;
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_front('0);
    endtask

    task automatic model_clock();
        bit [NN-1:0] ks;
        int w;
        bit nc;
        ks = hist.pop_back();
        hist.push_front(KEYS);
        w  = lowest(ks);
        nc = note_clks[m_sel];
        m_spk = (m_mode == M_PLAY || m_mode == M_DRAIN || m_mode == M_SUS) ? nc : 1'b0;
        case (m_mode)
            M_IDLE: if (w >= 0) begin m_sel = w; m_mode = M_ARM; end
            M_ARM: begin
                if (!ks[m_sel]) m_mode = M_IDLE;
                else if (!nc) m_mode = M_PLAY;
            end
            M_PLAY: begin
                if (!ks[m_sel] || (w >= 0 && w < m_sel)) begin
`ifdef NOTE_SCHED_SUSTAIN_EN
                    if (w < 0) begin m_mode = M_SUS; m_cnt = SC - 1; end
                    else m_mode = M_DRAIN;
`else
                    m_mode = M_DRAIN;
`endif
                end
            end
            M_SUS: begin
                if (w >= 0 || m_cnt == 0) m_mode = M_DRAIN;
                else m_cnt--;
            end
            default: begin
                if (!nc) begin
                    if (w >= 0) begin m_sel = w; m_mode = M_ARM; end
                    else m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    // High-pulse length tracker: every pulse must last a full note half-period.
    bit prev_spk;
    int run_len;
    int run_sel = -1;

    task automatic track_pulse();
        if (SPEAKER === 1'b1 && !prev_spk) begin
            run_len = 1;
            run_sel = NOTE_SEL;
        end else if (SPEAKER === 1'b1) begin
            run_len++;
        end else if (prev_spk && run_sel >= 0) begin
            chk("pulse_len", run_len, half_period(run_sel));
        end
        prev_spk = (SPEAKER === 1'b1);
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (RESET) model_reset();
        else model_clock();
        @(negedge CLK);
        chk("speaker", SPEAKER, m_spk);
        chk("note_sel", NOTE_SEL, m_sel);
        chk("note_valid", NOTE_VALID, (m_mode == M_PLAY || m_mode == M_SUS));
        if (RESET) begin
            prev_spk = 0;
            run_sel  = -1;
        end else begin
            track_pulse();
        end
        advance_nc();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    typedef struct {
        logic [NN-1:0] keys;
        logic [2:0]    exp_sel;
        logic          exp_valid;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n;
        RESET     = 1'b1;
        KEYS      = '0;
        note_clks = '0;
        for (int i = 0; i < NN; i++) begin nc_cnt[i] = 0; stuck[i] = 0; end
        model_reset();

        vecs.push_back('{8'h01, 3'd0, 1'b1});
        vecs.push_back('{8'h03, 3'd0, 1'b1});
        vecs.push_back('{8'h00, 3'd0, 1'b0});
        vecs.push_back('{8'h80, 3'd7, 1'b1});
        vecs.push_back('{8'h81, 3'd0, 1'b1});
        vecs.push_back('{8'h24, 3'd2, 1'b1});
        vecs.push_back('{8'h20, 3'd5, 1'b1});
        vecs.push_back('{8'h00, 3'd5, 1'b0});
        vecs.push_back('{8'hff, 3'd0, 1'b1});
        vecs.push_back('{8'hfe, 3'd1, 1'b1});
        vecs.push_back('{8'h40, 3'd6, 1'b1});
        vecs.push_back('{8'h00, 3'd6, 1'b0});

        run(3);
        chk("reset_speaker", SPEAKER, 0);
        chk("reset_sel", NOTE_SEL, 0);
        chk("reset_valid", NOTE_VALID, 0);
        RESET = 1'b0;
        run(4);

        // Steady-state table: after settling, the lowest held key plays.
        foreach (vecs[v]) begin
            KEYS = vecs[v].keys;
            run(60);
            chk("vec_sel", NOTE_SEL, vecs[v].exp_sel);
            chk("vec_valid", NOTE_VALID, vecs[v].exp_valid);
        end

        // Asynchronous reset while a note is sounding.
        KEYS = 8'h01;
        n = 0;
        while (!(NOTE_VALID === 1'b1 && SPEAKER === 1'b1) && n < 200) begin cycle(); n++; end
        chk("wait_play", (n < 200), 1);
        #1 RESET = 1'b1;
        #1;
        chk("async_speaker", SPEAKER, 0);
        chk("async_valid", NOTE_VALID, 0);
        chk("async_sel", NOTE_SEL, 0);
        model_reset();
        prev_spk = 0;
        run_sel  = -1;
        run(2);
        RESET = 1'b0;
        cycle();
        chk("idle_after_reset", NOTE_VALID, 0);
        run(40);
        chk("replay_after_reset", NOTE_VALID, 1);

        // Note clock stuck high: ARM waits forever without sounding.
        KEYS = '0;
        run(40);
        stuck[4] = 1;
        note_clks[4] = 1'b1;
        KEYS = 8'h10;
        run(60);
        chk("stuck_sel", NOTE_SEL, 4);
        chk("stuck_valid", NOTE_VALID, 0);
        stuck[4] = 0;
        note_clks[4] = 1'b0;
        nc_cnt[4] = 0;
        run(30);
        chk("unstuck_valid", NOTE_VALID, 1);

        // Release and quick re-press of the same key during its drain.
        KEYS = 8'h80;
        run(40);
        KEYS = 8'h00;
        run(3);
        KEYS = 8'h80;
        run(40);
        chk("repress_sel", NOTE_SEL, 7);
        chk("repress_valid", NOTE_VALID, 1);

`ifdef NOTE_SCHED_SUSTAIN_EN
        KEYS = 8'h08;
        run(40);
        KEYS = 8'h00;
        n = 0;
        while (NOTE_VALID === 1'b1 && n < 100) begin cycle(); n++; end
        chk("sustain_len", n, SS + SC);
        run(20);
        KEYS = 8'h08;
        run(40);
        KEYS = 8'h00;
        run(4);
        KEYS = 8'h02;
        run(40);
        chk("sustain_abort_sel", NOTE_SEL, 1);
        chk("sustain_abort_valid", NOTE_VALID, 1);
`endif

        // Randomized key traffic, mostly sparse key sets with varied hold times.
        for (int s = 0; s < 500; s++) begin
            KEYS = NN'($urandom & $urandom & $urandom);
            run($urandom_range(1, 25));
        end
        KEYS = '0;
        run(40);
        chk("final_valid", NOTE_VALID, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
